// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the interval-timer tick scheduler.
package timer_sched_pkg;

    typedef enum logic [2:0] {
        RST,
        INIT_PL,
        INIT_PH,
        INIT_CTRL,
        CLR,
        IDLE,
        ACK,
        GUARD
    } state_t;

    localparam logic [2:0]  STATUS   = 3'd0;
    localparam logic [2:0]  CONTROL  = 3'd1;
    localparam logic [2:0]  PERIOD_L = 3'd2;
    localparam logic [2:0]  PERIOD_H = 3'd3;

    localparam logic [15:0] CTRL_ITO = 16'h0001;

endpackage

// File: rtl/timer_tick_channel.sv
// One periodic channel: counts base ticks down from its reload value and
// pulses expire on every reload-th tick.
module timer_tick_channel
    import timer_sched_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             cfg_wr,
    input  logic [CNT_W-1:0] cfg_period,
    output logic             expire
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] reload_reg;
    logic [CNT_W-1:0] count_reg;
    logic             enable_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_reg <= '0;
            count_reg  <= '0;
            enable_reg <= 1'b0;
            expire     <= 1'b0;
        end else begin
            expire <= 1'b0;
            // A configuration write swallows a coincident tick entirely.
            if (cfg_wr) begin
                reload_reg <= cfg_period;
                count_reg  <= cfg_period;
                enable_reg <= (cfg_period != '0);
            end else if (tick && enable_reg) begin
                if (count_reg == ONE) begin
                    count_reg <= reload_reg;
                    expire    <= 1'b1;
                end else begin
                    count_reg <= count_reg - ONE;
                end
            end
        end
    end

endmodule

// File: rtl/timer_tick_scheduler.sv
// Programs the interval timer over its register port, acknowledges each
// timeout and fans the resulting base tick out to NUM_CH periodic channels.
module timer_tick_scheduler
    import timer_sched_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] TICK_PERIOD = 32'd49999,
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic              tmr_irq,
    input  logic              per_wr,
    input  logic [31:0]       per_value,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    output logic              init_done,
    output logic              tick,
    output logic [NUM_CH-1:0] ch_expire
);

    state_t      state_reg;
    logic [31:0] period_reg;
    logic        per_pending_reg;
    logic        per_req;
    logic [31:0] period_now;

    // A request arriving in the deciding cycle itself still beats a timeout.
    assign per_req    = per_pending_reg | per_wr;
    assign period_now = per_wr ? per_value : period_reg;

    // Outputs are registered on entry, so each state's write is on the bus
    // for exactly the cycle the FSM sits in that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= RST;
            period_reg      <= TICK_PERIOD;
            per_pending_reg <= 1'b0;
            tmr_chipselect  <= 1'b0;
            tmr_write_n     <= 1'b1;
            tmr_address     <= STATUS;
            tmr_writedata   <= '0;
            init_done       <= 1'b0;
            tick            <= 1'b0;
        end else begin
            tmr_chipselect  <= 1'b0;
            tmr_write_n     <= 1'b1;
            tick            <= 1'b0;
            per_pending_reg <= per_pending_reg | per_wr;
            if (per_wr) begin
                period_reg <= per_value;
            end

            case (state_reg)
                RST: begin
                    state_reg       <= INIT_PL;
                    per_pending_reg <= 1'b0;
                    tmr_chipselect  <= 1'b1;
                    tmr_write_n     <= 1'b0;
                    tmr_address     <= PERIOD_L;
                    tmr_writedata   <= period_now[15:0];
                end
                INIT_PL: begin
                    state_reg      <= INIT_PH;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= PERIOD_H;
                    tmr_writedata  <= period_reg[31:16];
                end
                INIT_PH: begin
                    state_reg      <= INIT_CTRL;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= CONTROL;
                    tmr_writedata  <= CTRL_ITO;
                end
                INIT_CTRL: begin
                    state_reg      <= CLR;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= STATUS;
                    tmr_writedata  <= '0;
                end
                CLR: begin
                    state_reg <= IDLE;
                    init_done <= 1'b1;
                end
                IDLE: begin
                    if (per_req) begin
                        state_reg       <= INIT_PL;
                        per_pending_reg <= 1'b0;
                        tmr_chipselect  <= 1'b1;
                        tmr_write_n     <= 1'b0;
                        tmr_address     <= PERIOD_L;
                        tmr_writedata   <= period_now[15:0];
                    end else if (tmr_irq) begin
                        state_reg      <= ACK;
                        tick           <= 1'b1;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_address    <= STATUS;
                        tmr_writedata  <= '0;
                    end
                end
                ACK:     state_reg <= GUARD;
                GUARD:   state_reg <= IDLE;
                default: state_reg <= RST;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        timer_tick_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .cfg_wr     (cfg_wr && (cfg_ch == CH_W'(gi))),
            .cfg_period (cfg_period),
            .expire     (ch_expire[gi])
        );
    end

endmodule
